// File: rtl/tdm_demux_1x8.sv
// Time-division demultiplexer: serial slot stream -> 8 parallel channels.
// Optional macro TDM_DEMUX_PARITY_EN adds a 9th even-parity slot per frame.
module tdm_demux_1x8 #(
    parameter bit REQUIRE_SYNC = 1'b1
`ifdef TDM_DEMUX_PARITY_EN
    , localparam int SEL_W = 4
    , localparam int LAST  = 8
`else
    , localparam int SEL_W = 3
    , localparam int LAST  = 7
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             frame_sync,
    output logic [7:0]       dout,
    output logic [SEL_W-1:0] sel,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic             parity_err
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [0:0] ST_RESET = REQUIRE_SYNC ? ST_HUNT : ST_LOCK;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(LAST);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       dout_q, dout_d;
    logic             fv_q, fv_d;
    logic             se_q, se_d;
    logic             pe_d;

    logic             slot_go;
    logic             misaligned;
    logic             frame_end;

    // Classify the current enabled slot before deciding the next state.
    always_comb begin
        slot_go    = en && (state_q == ST_LOCK);
        misaligned = slot_go && frame_sync && (sel_q != '0);
        frame_end  = slot_go && !misaligned && (sel_q == SEL_LAST);
    end

    // Next-state: slot steering, frame publish and realignment.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        pe_d     = 1'b0;
        if (en && state_q == ST_HUNT) begin
            if (frame_sync) begin
                state_d  = ST_LOCK;
                shadow_d = {7'b0, din};
                sel_d    = SEL_ONE;
            end
        end else if (misaligned) begin
            // Drop the partial frame; this bit becomes slot 0.
            se_d     = 1'b1;
            shadow_d = {7'b0, din};
            sel_d    = SEL_ONE;
        end else if (frame_end) begin
`ifdef TDM_DEMUX_PARITY_EN
            dout_d = shadow_q;
            pe_d   = ^{shadow_q, din};
`else
            dout_d = {din, shadow_q[6:0]};
`endif
            fv_d     = 1'b1;
            sel_d    = '0;
            shadow_d = '0;
        end else if (slot_go) begin
            shadow_d[sel_q[2:0]] = din;
            sel_d                = sel_q + SEL_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RESET;
            sel_q    <= '0;
            shadow_q <= '0;
            dout_q   <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic pe_q;

    // Parity error pulse, aligned with frame_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_q <= 1'b0;
        end else begin
            pe_q <= pe_d;
        end
    end

    assign parity_err = pe_q;
`else
    logic unused_pe;
    assign unused_pe  = pe_d;
    assign parity_err = 1'b0;
`endif

    assign dout        = dout_q;
    assign sel         = sel_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == ST_LOCK);
    assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8 with a queue-based frame model.
// Honours TDM_DEMUX_PARITY_EN to select 8- or 9-slot frames.
module tb_tdm_demux_1x8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NS = 9;
    localparam int SW = 4;
`else
    localparam int NS = 8;
    localparam int SW = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          din = 1'b0;
    logic          fs  = 1'b0;
    logic [7:0]    dout;
    logic [SW-1:0] sel;
    logic          fv;
    logic          locked;
    logic          se;
    logic          pe;

    int total = 0;
    int bad   = 0;

    tdm_demux_1x8 #(.REQUIRE_SYNC(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .frame_sync  (fs),
        .dout        (dout),
        .sel         (sel),
        .frame_valid (fv),
        .locked      (locked),
        .sync_err    (se),
        .parity_err  (pe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %0h want %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Model: bits collected since the frame start live in a queue.
    bit         m_locked = 1'b0;
    int         q[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_fv = 1'b0;
    bit         m_se = 1'b0;
    bit         m_pe = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_locked = 1'b0;
            q.delete();
            m_dout = 8'h00;
            m_fv = 1'b0;
            m_se = 1'b0;
            m_pe = 1'b0;
        end else begin
            m_fv = 1'b0;
            m_se = 1'b0;
            m_pe = 1'b0;
            if (en) begin
                if (!m_locked) begin
                    if (fs) begin
                        m_locked = 1'b1;
                        q.delete();
                        q.push_back(int'(din));
                    end
                end else if (fs && q.size() != 0) begin
                    m_se = 1'b1;
                    q.delete();
                    q.push_back(int'(din));
                end else begin
                    q.push_back(int'(din));
                    if (q.size() == NS) begin
                        int x;
                        x = 0;
                        m_dout = 8'h00;
                        for (int i = 0; i < 8; i++)
                            m_dout[i] = q[i][0];
                        foreach (q[i]) x = x ^ q[i];
                        m_fv = 1'b1;
                        m_pe = (NS == 9) ? x[0] : 1'b0;
                        q.delete();
                    end
                end
            end
        end
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("sel", 32'(sel), 32'(q.size()));
        chk("frame_valid", 32'(fv), 32'(m_fv));
        chk("sync_err", 32'(se), 32'(m_se));
        chk("parity_err", 32'(pe), 32'(m_pe));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("fv_se_excl", 32'(fv & se), 32'd0);
    end

    task automatic step(input logic r, input logic e, input logic d,
                        input logic s);
        rst = r;
        en  = e;
        din = d;
        fs  = s;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic par);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, v[i], i == 0);
        if (NS == 9)
            step(1'b0, 1'b1, par, 1'b0);
    endtask

    initial begin
        int fv_seen;
        logic [7:0] pat;
        pat = 8'h65;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_fv", 32'(fv), 32'd0);

        fv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'(i % 2), 1'b0);
            fv_seen += int'(fv);
        end
        chk("hunt_locked", 32'(locked), 32'd0);
        chk("hunt_dout", 32'(dout), 32'h00);
        chk("hunt_fv_seen", 32'(fv_seen), 32'd0);

        step(1'b0, 1'b1, pat[0], 1'b1);
        chk("lock_after_sync", 32'(locked), 32'd1);
        chk("sel_after_sync", 32'(sel), 32'd1);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b1, pat[i], 1'b0);
        if (NS == 9)
            step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("frame1_dout", 32'(dout), 32'h65);
        chk("frame1_fv", 32'(fv), 32'd1);
        chk("frame1_sel", 32'(sel), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frame1_fv_pulse", 32'(fv), 32'd0);

        for (int i = 0; i < NS; i++) begin
            step(1'b0, 1'b1, (i < 8) ? pat[i] : 1'b0, i == 0);
            if (i < NS - 1) begin
                chk("gap_fv_low", 32'(fv), 32'd0);
                step(1'b0, 1'b0, 1'b1, 1'b1);
                chk("gap_sel_hold", 32'(sel), 32'(i + 1));
            end
        end
        chk("gap_dout", 32'(dout), 32'h65);
        chk("gap_fv", 32'(fv), 32'd1);

        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_mis_sel", 32'(sel), 32'd4);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("mis_se", 32'(se), 32'd1);
        chk("mis_fv", 32'(fv), 32'd0);
        chk("mis_dout", 32'(dout), 32'h65);
        chk("mis_sel", 32'(sel), 32'd1);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0);
        if (NS == 9)
            step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("realign_dout", 32'(dout), 32'hFF);
        chk("realign_fv", 32'(fv), 32'd1);
        chk("realign_se", 32'(se), 32'd0);

        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_sel", 32'(sel), 32'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_dout", 32'(dout), 32'h00);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_fv", 32'(fv), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(8'h65, 1'b1);
        chk("par_bad_pe", 32'(pe), 32'd1);
        chk("par_bad_fv", 32'(fv), 32'd1);
        chk("par_bad_dout", 32'(dout), 32'h65);
        send_frame(8'h65, 1'b0);
        chk("par_ok_pe", 32'(pe), 32'd0);
        chk("par_ok_fv", 32'(fv), 32'd1);
`else
        send_frame(8'hA3, 1'b0);
        chk("frame_a3_dout", 32'(dout), 32'hA3);
        chk("frame_a3_pe", 32'(pe), 32'd0);
`endif

        for (int c = 0; c < 4000; c++) begin
            logic r, e, d, s;
            r = ($urandom % 600) == 0;
            e = ($urandom % 4) != 0;
            d = 1'($urandom % 2);
            if (q.size() == 0)
                s = ($urandom % 3) == 0;
            else
                s = ($urandom % 50) == 0;
            step(r, e, d, s);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Time-division demultiplexer: the receive end of the 8:1 mux datapath.
- Takes one serial bit per enabled cycle from a time-slotted stream, steers it to one of 8 channel slots using an internal 3-bit slot counter, and publishes all 8 channels together at end of frame.
- Sits between the serial link and the parallel consumer logic.
- Frame alignment comes from a frame_sync strobe that marks slot 0.

Parameters:
- REQUIRE_SYNC, 1, 1: after reset, ignore data until the first frame_sync (HUNT state). 0: start LOCKED at slot 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  slot strobe; din/frame_sync sampled only when en=1
- din  input  1  serial data bit for the current slot
- frame_sync  input  1  qualified by en; marks that din is slot 0
- dout  output  8  last complete frame; dout[i] = channel i
- sel  output  3  slot index the next enabled bit will be written to
- frame_valid  output  1  one-cycle pulse when dout is updated
- locked  output  1  1 in LOCKED state
- sync_err  output  1  one-cycle pulse when frame_sync arrives mid-frame
- parity_err  output  1  see Optional Feature; constant 0 when disabled

Behaviour:
- Reset (rst=1 at clock edge) gives: dout=0, sel=0, frame_valid=0, sync_err=0, parity_err=0, internal shadow register=0, locked = (REQUIRE_SYNC ? 0 : 1). Reset overrides all other inputs. Reset mid-frame discards the partial frame.
- State HUNT (locked=0):
  - en=1 & frame_sync=1: shadow[0]<=din, sel<=1, go LOCKED.
  - All other inputs: no change.
- State LOCKED (locked=1):
  - en=0: sel, shadow and dout hold; frame_valid=0.
  - en=1 & frame_sync=0: shadow[sel]<=din, sel<=sel+1 (3-bit, wraps 7->0).
  - en=1 & sel==7 (frame_sync=0):
    - dout <= {din, shadow[6:0]} on the same edge; frame_valid=1 for exactly the following cycle.
    - sel<=0; shadow cleared.
  - en=1 & frame_sync=1 & sel==0: normal slot-0 write, no error.
  - en=1 & frame_sync=1 & sel!=0 (misaligned):
    - sync_err pulses one cycle; partial frame discarded (shadow cleared); dout unchanged; no frame_valid.
    - The bit is realigned as slot 0: shadow[0]<=din, sel<=1. Stays LOCKED.
- Output latency: dout/frame_valid are registered and appear the cycle after the edge that samples slot 7.
- frame_valid and sync_err are never high together.
- Back-to-back frames with en held high produce a frame_valid pulse every 8 cycles with no gap.
- frame_sync with en=0 is ignored in all states.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN
- Defined:
  - Frame is 9 slots; slot 8 carries even parity over channels 0..7. sel widens to 4 bits and wraps 8->0.
  - dout/frame_valid update when slot 8 is sampled.
  - parity_err is a one-cycle pulse coincident with frame_valid if XOR(dout, parity bit) != 0. dout is still updated.
  - A misaligned frame_sync is one arriving with sel!=0 (sel range 0..8).
- Not defined: 8-slot frame as above; sel is 3 bits; parity_err tied 0.

Test Plan:
- Reset, REQUIRE_SYNC=1, en=1, din toggling, no frame_sync for 20 cycles -> locked=0, dout=8'h00, frame_valid never asserted.
- frame_sync with slot 0, then 8 enabled bits 1,0,1,0,0,1,1,0 (slot0..7) -> locked=1 after first bit; one cycle after slot 7, dout=8'h65 and frame_valid=1 for 1 cycle; sel=0.
- en toggled 1,0,1,0 across the same frame -> identical dout=8'h65; sel holds on en=0 cycles; frame_valid only after the 8th enabled bit.
- frame_sync at sel=4 -> sync_err=1 one cycle; dout keeps previous 8'h65; sel=1 next; a following 7 bits of 1 complete the frame with dout=8'hFF.
- rst asserted at sel=5 -> next cycle sel=0, dout=0, locked=0, no frame_valid.
- With TDM_DEMUX_PARITY_EN, frame 8'h65 with parity bit 1 -> parity_err=1 with frame_valid; repeat with parity bit 0 -> parity_err=0.
